// File: rtl/register_file.sv
// register_file: 32 x 32-bit general-purpose register file with a sequential
// clear engine. After reset the engine zeroes one register per clock and then
// raises READY. Register 0 is hardwired to zero. The two read ports are
// combinational.
// Optional build macro REGFILE_BYPASS_EN: when defined, the read ports forward
// same-cycle write data (write-to-read bypass). When undefined, a same-cycle
// read returns the pre-write value.
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32   // must equal 2**ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [ADDR_W-1:0] WritePort,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              REGWRITE,
  input  logic [ADDR_W-1:0] ReadPort1,
  input  logic [ADDR_W-1:0] ReadPort2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              READY
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   mem_q [NREGS];

  // Single array write port, shared by the clear engine and normal writeback.
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;

  logic [ADDR_W-1:0]   rd_addr [2];

  // Next-state logic: the clear engine owns the write port in CLEAR;
  // external writes are accepted only in RUN.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    wr_en     = 1'b0;
    wr_addr   = WritePort;
    wr_data   = WriteData;
    case (state_q)
      CLEAR: begin
        wr_en     = 1'b1;
        wr_addr   = clr_cnt_q;
        wr_data   = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_W'(NREGS - 1)) begin
          state_d   = RUN;
          ready_d   = 1'b1;
          clr_cnt_d = '0;
        end
      end
      RUN: begin
        // Writes to register 0 are discarded so it always reads as zero.
        wr_en = REGWRITE && (WritePort != '0);
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Control state register with synchronous active-low reset; reset restarts
  // the clear sequence from register 0.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  // Register array update; reset itself never touches the contents.
  always_ff @(posedge CLK) begin
    if (RESET_N && wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_addr[0] = ReadPort1;
  assign rd_addr[1] = ReadPort2;

  // Two identical, independent combinational read ports.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [DATA_W-1:0] rd_val;
      logic              bypass_hit;

`ifdef REGFILE_BYPASS_EN
      assign bypass_hit = ready_q && REGWRITE && (WritePort != '0) &&
                          (rd_addr[gi] == WritePort);
`else
      assign bypass_hit = 1'b0;
`endif

      // Read mux: zero while not ready or for register 0, else array/bypass.
      always_comb begin
        rd_val = mem_q[rd_addr[gi]];
        if (!ready_q || (rd_addr[gi] == '0)) begin
          rd_val = '0;
        end else if (bypass_hit) begin
          rd_val = WriteData;
        end
      end
    end
  endgenerate

  assign ReadData1 = g_rd[0].rd_val;
  assign ReadData2 = g_rd[1].rd_val;
  assign READY     = ready_q;

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed-vector bench for register_file. Inputs change
// 1 time unit after the rising edge, and outputs are sampled 1 time unit after
// that. Expected values are hand-computed constants. The same-cycle read
// expectation follows REGFILE_BYPASS_EN.
module tb_register_file;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic [ADDR_W-1:0] WritePort;
  logic [DATA_W-1:0] WriteData;
  logic              REGWRITE;
  logic [ADDR_W-1:0] ReadPort1;
  logic [ADDR_W-1:0] ReadPort2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              READY;

  int checks   = 0;
  int failures = 0;

  register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .WritePort (WritePort),
    .WriteData (WriteData),
    .REGWRITE  (REGWRITE),
    .ReadPort1 (ReadPort1),
    .ReadPort2 (ReadPort2),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2),
    .READY     (READY)
  );

  always #5 CLK = ~CLK;

  // Counts one comparison and reports it on a single line.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  // Advance past the next rising edge.
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Let combinational reads settle after input changes.
  task automatic settle;
    #1;
  endtask

  task automatic write_reg(input int addr, input logic [31:0] data);
    WritePort = ADDR_W'(addr);
    WriteData = data;
    REGWRITE  = 1'b1;
    tick();
    REGWRITE  = 1'b0;
  endtask

  // Call with RESET_N just released. READY must stay low through edge 31
  // and be high after edge 32. External writes are dropped at edge 32.
  task automatic run_clear(input string tag);
    for (int e = 1; e <= NREGS; e++) begin
      tick();
      if (e == NREGS) begin
        REGWRITE = 1'b0;
        check_eq($sformatf("%s_ready_e%0d", tag, e), {31'd0, READY}, 32'd1);
      end else if (e == 1 || e == NREGS - 1) begin
        check_eq($sformatf("%s_ready_e%0d", tag, e), {31'd0, READY}, 32'd0);
      end else if (READY !== 1'b0) begin
        check_eq($sformatf("%s_ready_early_e%0d", tag, e), {31'd0, READY}, 32'd0);
      end
    end
  endtask

  initial begin
    RESET_N   = 1'b0;
    WritePort = '0;
    WriteData = '0;
    REGWRITE  = 1'b0;
    ReadPort1 = '0;
    ReadPort2 = '0;

    // Reset held for 3 edges.
    repeat (3) tick();
    check_eq("rst_ready", {31'd0, READY}, 32'd0);
    check_eq("rst_rd1", ReadData1, 32'h0);
    check_eq("rst_rd2", ReadData2, 32'h0);

    // Power-up clear.
    RESET_N = 1'b1;
    run_clear("pwrup");

    // Preload every register with a nonzero pattern.
    for (int r = 1; r < NREGS; r++) write_reg(r, 32'hA000_0000 + 32'(r));
    ReadPort1 = 5'd3;
    settle();
    check_eq("preload_r3", ReadData1, 32'hA000_0003);

    // Reset for 3 edges with writes pending, then release.
    // Writes to reg 7 are driven throughout the clear.
    RESET_N   = 1'b0;
    WritePort = 5'd7;
    WriteData = 32'hFFFF_FFFF;
    REGWRITE  = 1'b1;
    repeat (3) tick();
    check_eq("rst2_ready", {31'd0, READY}, 32'd0);
    RESET_N   = 1'b1;
    ReadPort1 = 5'd7;
    ReadPort2 = 5'd3;
    settle();
    check_eq("clear_rd1_r7", ReadData1, 32'h0);
    check_eq("clear_rd2_r3", ReadData2, 32'h0);
    run_clear("clr2");

    // Every register must read zero after the clear.
    for (int r = 0; r < NREGS; r += 2) begin
      ReadPort1 = ADDR_W'(r);
      ReadPort2 = ADDR_W'(r + 1);
      settle();
      check_eq($sformatf("zero_r%0d", r), ReadData1, 32'h0);
      check_eq($sformatf("zero_r%0d", r + 1), ReadData2, 32'h0);
    end

    // Basic write, then read on both ports.
    ReadPort1 = 5'd5;
    ReadPort2 = 5'd5;
    write_reg(5, 32'hDEAD_BEEF);
    check_eq("wr5_rd1", ReadData1, 32'hDEAD_BEEF);
    check_eq("wr5_rd2", ReadData2, 32'hDEAD_BEEF);

    // Register 0 is hardwired to zero; register 31 is an ordinary register.
    ReadPort1 = 5'd0;
    WritePort = 5'd0;
    WriteData = 32'h1234_5678;
    REGWRITE  = 1'b1;
    settle();
    check_eq("r0_samecycle", ReadData1, 32'h0);
    tick();
    REGWRITE = 1'b0;
    write_reg(31, 32'hCAFE_F00D);
    ReadPort1 = 5'd0;
    ReadPort2 = 5'd31;
    settle();
    check_eq("r0_read", ReadData1, 32'h0);
    check_eq("r31_read", ReadData2, 32'hCAFE_F00D);

    // Same-cycle read and write of reg 9. Port 2 independently reads reg 5.
    write_reg(9, 32'h1111_1111);
    ReadPort1 = 5'd9;
    ReadPort2 = 5'd5;
    WritePort = 5'd9;
    WriteData = 32'h2222_2222;
    REGWRITE  = 1'b1;
    settle();
`ifdef REGFILE_BYPASS_EN
    check_eq("rw9_before_edge", ReadData1, 32'h2222_2222);
`else
    check_eq("rw9_before_edge", ReadData1, 32'h1111_1111);
`endif
    check_eq("rw9_port2_r5", ReadData2, 32'hDEAD_BEEF);
    tick();
    REGWRITE = 1'b0;
    check_eq("rw9_after_edge", ReadData1, 32'h2222_2222);

    // Reset in the middle of operation.
    write_reg(3, 32'hA5A5_A5A5);
    ReadPort1 = 5'd3;
    settle();
    check_eq("mid_r3_pre", ReadData1, 32'hA5A5_A5A5);
    RESET_N = 1'b0;
    tick();
    check_eq("mid_rst_ready", {31'd0, READY}, 32'd0);
    check_eq("mid_rst_rd1", ReadData1, 32'h0);
    RESET_N = 1'b1;
    repeat (10) tick();
    check_eq("mid_clr10_ready", {31'd0, READY}, 32'd0);
    RESET_N = 1'b0;
    tick();
    check_eq("mid_rst2_ready", {31'd0, READY}, 32'd0);
    RESET_N = 1'b1;
    run_clear("mid");
    ReadPort1 = 5'd3;
    ReadPort2 = 5'd9;
    settle();
    check_eq("mid_r3_cleared", ReadData1, 32'h0);
    check_eq("mid_r9_cleared", ReadData2, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32 x 32-bit general-purpose register file; write stage directly downstream of the write-port select mux.
- Consumes the selected 5-bit write address (rd/rt, or 31 for link), the writeback data and the write enable; supplies two operand read ports to decode/execute.
- Contains a sequential clear engine: after reset it zeroes every register one per cycle, then asserts READY.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width.
- NREGS, 32, number of registers; must equal 2**ADDR_W.

Ports:
- CLK  input  1  sole clock; all state updates on rising edge.
- RESET_N  input  1  synchronous active-low reset.
- WritePort  input  ADDR_W  write address, from the write-port select mux.
- WriteData  input  DATA_W  writeback data.
- REGWRITE  input  1  write enable.
- ReadPort1  input  ADDR_W  read address A.
- ReadPort2  input  ADDR_W  read address B.
- ReadData1  output  DATA_W  read data A.
- ReadData2  output  DATA_W  read data B.
- READY  output  1  high once the clear sequence is complete; register file usable.

Behaviour:
- One clock (CLK); reset is synchronous and active-low (RESET_N), sampled only on the CLK rising edge.
- State machine, 2 states: CLEAR, RUN. Clear counter clr_cnt, ADDR_W bits.
- Reset (RESET_N=0 at the edge): state<=CLEAR, clr_cnt<=0, READY<=0. Holding reset keeps these values. Register contents are not otherwise touched by reset.
- Reset mid-operation, in CLEAR or RUN: restarts the clear sequence from 0.
- CLEAR with RESET_N=1: each edge writes 0 to reg[clr_cnt] and increments clr_cnt.
  - On the edge that clears reg[NREGS-1]: state<=RUN, READY<=1, clr_cnt wraps to 0.
  - READY therefore rises on the 32nd rising edge after the first edge with RESET_N=1.
- CLEAR ignores REGWRITE entirely; no external write reaches the array.
- RUN: on an edge with REGWRITE=1 and WritePort!=0, reg[WritePort]<=WriteData. Write latency is 1 edge.
- Register 0 is hardwired zero:
  - writes to address 0 are discarded;
  - reads of address 0 return 0.
- Address 31 (link) is an ordinary register.
- Reads are combinational (zero latency) from the array; both ports are independent and may use the same address.
- ReadData1/2 are forced to 0 while READY=0.
- Same-cycle read and write of one address, base build: the read returns the old value; the new value is visible after the edge.
- READY stays 1 in RUN until the next reset. No other state transitions.
- Outputs after reset: READY=0, ReadData1=ReadData2=0.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-to-read bypass. When READY=1, REGWRITE=1, WritePort!=0 and ReadPortN==WritePort, ReadDataN=WriteData combinationally in the same cycle. This removes the WB->ID hazard.
- Not defined: no bypass; same-cycle reads return the pre-write value. Base behaviour as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset/clear:
  - Preload via writes.
  - Assert RESET_N=0 for 3 edges, then release.
  - Required: READY=0 for exactly 31 edges after release and 1 after the 32nd.
  - All 32 registers then read 0x00000000.
- Basic write/read:
  - After READY, write WritePort=5, WriteData=0xDEADBEEF, REGWRITE=1.
  - Next cycle ReadPort1=5 -> ReadData1=0xDEADBEEF.
  - ReadPort2=5 simultaneously -> ReadData2=0xDEADBEEF.
- R0 and link:
  - Write 0x12345678 to address 0, then 0xCAFEF00D to address 31.
  - Required: read 0 -> 0x00000000; read 31 -> 0xCAFEF00D.
- Write blocked during clear:
  - Release reset and drive REGWRITE=1, WritePort=7, WriteData=0xFFFFFFFF on every cycle of CLEAR.
  - Required: after READY, reg 7 reads 0x00000000.
  - Reads during CLEAR return 0.
- Same-cycle read/write:
  - reg 9 = 0x11111111; write 0x22222222 to 9 while ReadPort1=9.
  - Base build, before the edge: ReadData1=0x11111111.
  - With REGFILE_BYPASS_EN: ReadData1=0x22222222.
  - Both builds after the edge: ReadData1=0x22222222.
- Reset mid-operation:
  - In RUN with reg 3 = 0xA5A5A5A5, assert RESET_N=0 for 1 edge, release after 10 more edges, then assert again.
  - Required: clr_cnt restarts at 0 and READY=0.
  - A full 32-edge clear is required after the final release; reg 3 reads 0 afterwards.
